valid_ready_asynchronous_fifo: RTL and testbench

- Clock-domain-crossing FIFO with a valid/ready handshake on both sides.
- Moves WIDTH-bit words from the write_clock domain to the read_clock domain.
- Uses Gray-coded pointers passed through STAGES-deep synchronizers.
- Sits between independently clocked producer and consumer blocks.
- Read data is first-word fall-through.

---
 rtl/vector_synchronizer.sv | 35 +++
 rtl/valid_ready_asynchronous_fifo.sv | 120 ++++++++++++
 tb/tb_valid_ready_asynchronous_fifo.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vector_synchronizer.sv
// Multi-flop synchronizer for a Gray-coded vector crossing into the
// clock domain of `clock`.
// Ports: clock, resetn (sync, active-low), data_in (source domain),
//        data_out (last stage, destination domain).
module vector_synchronizer #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = data_in;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync_q <= '{default: '0};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign data_out = sync_q[STAGES-1];

endmodule

// File: rtl/valid_ready_asynchronous_fifo.sv
// Dual-clock FIFO with valid/ready on both sides, Gray pointers crossing
// via synchronizers, and first-word fall-through read data.
// Ports: write_clock/write_resetn/write_data/write_valid -> write_ready,
//        write_full; read_clock/read_resetn/read_ready -> read_data,
//        read_valid, read_empty. Resets are synchronous, active-low.
module valid_ready_asynchronous_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             write_clock,
    input  logic             write_resetn,
    input  logic [WIDTH-1:0] write_data,
    input  logic             write_valid,
    output logic             write_ready,
    output logic             write_full,
    input  logic             read_clock,
    input  logic             read_resetn,
    output logic [WIDTH-1:0] read_data,
    output logic             read_valid,
    input  logic             read_ready,
    output logic             read_empty
);

    localparam int ADDR = $clog2(DEPTH);
    localparam int PW   = ADDR + 1;

    // Full when the write Gray pointer equals the read Gray pointer with
    // its two MSBs flipped (write side is exactly one lap ahead).
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic [PW-1:0] rgray_sync;
    logic [PW-1:0] wgray_sync;

    logic write_fire;
    logic read_fire;

    // ---------------- write domain ----------------
    assign write_full  = (wgray_q == (rgray_sync ^ FULL_MASK));
    assign write_ready = !write_full;
    assign write_fire  = write_valid && write_ready;

    always_comb begin
        wptr_d  = wptr_q;
        if (write_fire) begin
            wptr_d = wptr_q + PW'(1);
        end
        wgray_d = wptr_d ^ (wptr_d >> 1);
    end

    always_ff @(posedge write_clock) begin
        if (!write_resetn) begin
            wptr_q  <= '0;
            wgray_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            wgray_q <= wgray_d;
        end
    end

    always_ff @(posedge write_clock) begin
        if (write_fire && write_resetn) begin
            mem_q[wptr_q[ADDR-1:0]] <= write_data;
        end
    end

    vector_synchronizer #(
        .WIDTH  (PW),
        .STAGES (STAGES)
    ) u_rgray_sync (
        .clock    (write_clock),
        .resetn   (write_resetn),
        .data_in  (rgray_q),
        .data_out (rgray_sync)
    );

    // ---------------- read domain ----------------
    assign read_empty = (wgray_sync == rgray_q);
    assign read_valid = !read_empty;
    assign read_fire  = read_valid && read_ready;

    // The addressed entry cannot be overwritten while it is unread, so
    // this cross-domain read is stable whenever read_valid is high.
    assign read_data  = mem_q[rptr_q[ADDR-1:0]];

    always_comb begin
        rptr_d  = rptr_q;
        if (read_fire) begin
            rptr_d = rptr_q + PW'(1);
        end
        rgray_d = rptr_d ^ (rptr_d >> 1);
    end

    always_ff @(posedge read_clock) begin
        if (!read_resetn) begin
            rptr_q  <= '0;
            rgray_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            rgray_q <= rgray_d;
        end
    end

    vector_synchronizer #(
        .WIDTH  (PW),
        .STAGES (STAGES)
    ) u_wgray_sync (
        .clock    (read_clock),
        .resetn   (read_resetn),
        .data_in  (wgray_q),
        .data_out (wgray_sync)
    );

endmodule

// File: tb/tb_valid_ready_asynchronous_fifo.sv
// Randomized and directed bench for valid_ready_asynchronous_fifo,
// checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_valid_ready_asynchronous_fifo;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int STAGES = 2;

    logic             write_clock = 1'b0;
    logic             write_resetn = 1'b0;
    logic [WIDTH-1:0] write_data = '0;
    logic             write_valid = 1'b0;
    logic             write_ready;
    logic             write_full;
    logic             read_clock = 1'b0;
    logic             read_resetn = 1'b0;
    logic [WIDTH-1:0] read_data;
    logic             read_valid;
    logic             read_ready = 1'b0;
    logic             read_empty;

    valid_ready_asynchronous_fifo #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .STAGES (STAGES)
    ) dut (
        .write_clock  (write_clock),
        .write_resetn (write_resetn),
        .write_data   (write_data),
        .write_valid  (write_valid),
        .write_ready  (write_ready),
        .write_full   (write_full),
        .read_clock   (read_clock),
        .read_resetn  (read_resetn),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .read_ready   (read_ready),
        .read_empty   (read_empty)
    );

    realtime wper = 10.0;
    realtime rper = 10.0;

    always begin
        #(wper / 2.0) write_clock = ~write_clock;
    end

    initial begin
        #2.5;
        forever #(rper / 2.0) read_clock = ~read_clock;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model: words accepted but not yet consumed, in order.
    logic [WIDTH-1:0] model_q[$];

    bit mon_on = 0;
    int wr_mode = 0;
    int rd_mode = 0;
    int wr_sent = 0;
    int wr_target = 0;
    int rd_got = 0;
    int rd_target = 0;
    bit wr_took = 0;

    // Write-side monitor: the inputs and write_ready are stable from the
    // posedge+1 drive point to the next posedge, so sampling here tells
    // whether the coming edge performs a transfer.
    always @(negedge write_clock) begin
        if (mon_on) begin
            check("wr_ready_eq", write_ready, !write_full);
            if (!write_full) begin
                check("not_full_room", model_q.size() < DEPTH, 1);
            end
            if (write_valid && write_ready) begin
                model_q.push_back(write_data);
                wr_sent++;
                wr_took = 1;
            end
        end
    end

    always @(negedge read_clock) begin
        if (mon_on) begin
            check("rd_valid_eq", read_valid, !read_empty);
            if (read_valid) begin
                check("valid_has_data", model_q.size() != 0, 1);
            end
            if (read_valid && read_ready && model_q.size() != 0) begin
                check("rd_data", read_data, model_q.pop_front());
                rd_got++;
            end
        end
    end

    always @(posedge write_clock) begin
        #1;
        if (wr_mode != 0) begin
            if (!(write_valid && !wr_took)) begin
                write_valid = (wr_sent < wr_target) &&
                              (wr_mode == 1 || $urandom_range(1) == 1);
                write_data  = WIDTH'($urandom);
            end
        end
        wr_took = 0;
    end

    always @(posedge read_clock) begin
        #1;
        if (rd_mode != 0) begin
            read_ready = (rd_got < rd_target) &&
                         (rd_mode == 1 || $urandom_range(1) == 1);
        end
    end

    task automatic settle_check(input string tag);
        repeat (STAGES + 2) @(posedge write_clock);
        repeat (STAGES + 2) @(posedge read_clock);
        @(negedge read_clock);
        check({tag, "_empty"}, read_empty, 1);
        @(negedge write_clock);
        check({tag, "_full"}, write_full, 0);
    endtask

    task automatic run_phase(input string tag, input realtime wp,
                             input realtime rp, input int mode);
        wper = wp;
        rper = rp;
        repeat (3) @(posedge write_clock);
        wr_target = wr_sent + 100;
        rd_target = rd_got + 100;
        wr_mode = mode;
        rd_mode = mode;
        for (int c = 0; c < 5000 && rd_got < rd_target; c++) begin
            @(posedge read_clock);
        end
        check({tag, "_done"}, rd_got >= rd_target, 1);
        wr_mode = 0;
        rd_mode = 0;
        @(posedge write_clock);
        #1 write_valid = 0;
        @(posedge read_clock);
        #1 read_ready = 0;
        settle_check(tag);
        check({tag, "_model_empty"}, model_q.size(), 0);
    endtask

    logic [WIDTH-1:0] fill_vals [4];

    initial begin
        fill_vals = '{8'h3A, 8'h11, 8'hFF, 8'h00};

        repeat (4) @(posedge write_clock);
        repeat (4) @(posedge read_clock);
        @(posedge write_clock);
        #1 write_resetn = 1;
        @(posedge read_clock);
        #1 read_resetn = 1;
        mon_on = 1;

        @(negedge read_clock);
        check("rst_read_valid", read_valid, 0);
        check("rst_read_empty", read_empty, 1);
        @(negedge write_clock);
        check("rst_write_ready", write_ready, 1);
        check("rst_write_full", write_full, 0);

        for (int i = 0; i < DEPTH; i++) begin
            @(posedge write_clock);
            #1;
            write_valid = 1;
            write_data  = fill_vals[i];
            @(posedge write_clock);
            #1 write_valid = 0;
            repeat (STAGES) @(posedge read_clock);
            @(negedge read_clock);
            check("fill_empty", read_empty, 0);
            check("fill_valid", read_valid, 1);
            @(negedge write_clock);
            check("fill_full", write_full, (i == DEPTH - 1));
            check("fill_ready", write_ready, (i != DEPTH - 1));
        end

        for (int i = 0; i < DEPTH; i++) begin
            @(posedge read_clock);
            #1 read_ready = 1;
            @(negedge read_clock);
            check("drain_data", read_data, fill_vals[i]);
            @(posedge read_clock);
            #1 read_ready = 0;
            repeat (STAGES) @(posedge write_clock);
            @(negedge write_clock);
            check("drain_full", write_full, 0);
        end
        @(negedge read_clock);
        check("drain_empty", read_empty, 1);
        check("drain_valid", read_valid, 0);
        @(negedge write_clock);
        check("drain_ready", write_ready, 1);
        check("drain_model", model_q.size(), 0);

        run_phase("tp_eq", 10.0, 10.0, 1);
        run_phase("tp_wfast", 3.18, 10.0, 1);
        run_phase("tp_rfast", 10.0, 3.18, 1);
        run_phase("rnd_eq", 10.0, 10.0, 2);
        run_phase("rnd_wfast", 3.18, 10.0, 2);
        run_phase("rnd_rfast", 10.0, 3.18, 2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
